// File: rtl/mmu_pkg.sv
// mmu_pkg: shared constants, error codes and release FSM states for the page allocator
package mmu_pkg;
    localparam int WIDTH = 64;
    localparam int POS_W = 7;
    localparam logic [1:0] ERR_NONE   = 2'd0;
    localparam logic [1:0] ERR_RANGE  = 2'd1;
    localparam logic [1:0] ERR_DOUBLE = 2'd2;
    typedef enum logic [1:0] {IDLE, DECODE, COMMIT} state_t;
endpackage

// File: rtl/pos_to_mask.sv
// pos_to_mask: decodes a 1-based page position into a one-hot mask plus out-of-range flag
module pos_to_mask #(
    parameter int WIDTH = mmu_pkg::WIDTH,
    parameter int POS_W = mmu_pkg::POS_W
) (
    input  logic [POS_W-1:0] pos,
    output logic [WIDTH-1:0] mask,
    output logic             range_err
);
    logic in_range;
    // position 0 means "none" and anything above WIDTH has no page behind it
    always_comb begin
        in_range  = (pos != '0) && (pos <= POS_W'(WIDTH));
        range_err = !in_range;
        mask      = in_range ? (WIDTH'(1) << (pos - POS_W'(1))) : '0;
    end
endmodule

// File: rtl/page_release.sv
// page_release: owns the page occupancy bitmap, commits allocations and validates/executes frees
module page_release #(
    parameter int WIDTH = mmu_pkg::WIDTH,
    parameter int POS_W = mmu_pkg::POS_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             free_valid,
    output logic             free_ready,
    input  logic [POS_W-1:0] free_pos,
    input  logic             alloc_valid,
    input  logic [WIDTH-1:0] alloc_mask,
    output logic [WIDTH-1:0] bitmap,
    output logic [POS_W-1:0] free_count,
    output logic             free_done,
    output logic             free_err,
    output logic [1:0]       err_code,
    output logic             alloc_err
);
    import mmu_pkg::*;

    state_t             state, state_n;
    logic [POS_W-1:0]   pos_q;
    logic [WIDTH-1:0]   mask_q, dec_mask, clr, set, next;
    logic               range_q, dec_range;
    logic               done_n, err_n, alloc_err_n;
    logic [1:0]         code_n;
    logic [4:0]         slice_cnt [4];
    logic [POS_W-1:0]   pop;

    pos_to_mask #(.WIDTH(WIDTH), .POS_W(POS_W)) u_dec (
        .pos       (pos_q),
        .mask      (dec_mask),
        .range_err (dec_range)
    );

    // release FSM: accept in IDLE, decode, then validate against the live bitmap and commit
    always_comb begin
        state_n    = state;
        free_ready = 1'b0;
        clr        = '0;
        done_n     = 1'b0;
        err_n      = 1'b0;
        code_n     = err_code;
        case (state)
            IDLE: begin
                free_ready = 1'b1;
                state_n    = free_valid ? DECODE : IDLE;
            end
            DECODE: state_n = COMMIT;
            COMMIT: begin
                state_n = IDLE;
                if (range_q) begin
                    err_n  = 1'b1;
                    code_n = ERR_RANGE;
                end else if ((bitmap & mask_q) == '0) begin
                    err_n  = 1'b1;
                    code_n = ERR_DOUBLE;
                end else begin
                    clr    = mask_q;
                    done_n = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // next bitmap: allocation sets win over a same-cycle release of the same page
    always_comb begin
        set         = alloc_valid ? alloc_mask : '0;
        next        = (bitmap & ~clr) | set;
        alloc_err_n = alloc_valid & |(alloc_mask & bitmap);
    end

    // popcount of the next bitmap as four 16-bit slice counts summed together
    always_comb begin
        for (int s = 0; s < 4; s++) begin
            slice_cnt[s] = '0;
            for (int b = 0; b < 16; b++) slice_cnt[s] = slice_cnt[s] + 5'(next[16*s+b]);
        end
        pop = (POS_W'(slice_cnt[0]) + POS_W'(slice_cnt[1])) + (POS_W'(slice_cnt[2]) + POS_W'(slice_cnt[3]));
    end

    // state, request latches, bitmap/count and result pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            pos_q      <= '0;
            mask_q     <= '0;
            range_q    <= 1'b0;
            bitmap     <= '0;
            free_count <= POS_W'(WIDTH);
            free_done  <= 1'b0;
            free_err   <= 1'b0;
            err_code   <= ERR_NONE;
            alloc_err  <= 1'b0;
        end else begin
            state      <= state_n;
            if (state == IDLE && free_valid) pos_q <= free_pos;
            if (state == DECODE) begin
                mask_q  <= dec_mask;
                range_q <= dec_range;
            end
            bitmap     <= next;
            free_count <= POS_W'(WIDTH) - pop;
            free_done  <= done_n;
            free_err   <= err_n;
            err_code   <= code_n;
            alloc_err  <= alloc_err_n;
        end
    end
endmodule
